pan_sequencer: RTL and testbench

Control block for the stereo panning datapath. It steps a pan position (0 = full left .. 8 = full right) once per programmable number of codec sample ticks, in one of four modes: centre, manual, ping-pong sweep, rotate. It emits complementary eighth-step gains to the panner and accepts run-time configuration over a valid/ready handshake. Sits between the control/UI logic and the panning datapath; clocked in the audio clock domain alongside the 48 kHz sample strobe.

---
 rtl/pan_pkg.sv | 47 ++++
 rtl/pan_dwell_counter.sv | 43 ++++
 rtl/pan_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pan_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pan_pkg.sv
// Shared encodings, position constants and helpers for the pan sequencer.
// Optional glide behaviour of MANUAL mode is selected with PAN_SMOOTH_EN.
package pan_pkg;

    typedef enum logic [1:0] {
        PAN_OFF    = 2'd0,
        PAN_MANUAL = 2'd1,
        PAN_SWEEP  = 2'd2,
        PAN_ROTATE = 2'd3
    } pan_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CENTRE     = 3'd1,
        ST_MANUAL     = 3'd2,
        ST_SWEEP_UP   = 3'd3,
        ST_SWEEP_DOWN = 3'd4,
        ST_ROTATE     = 3'd5
    } pan_state_e;

    localparam logic [3:0] POS_MAX    = 4'd8;
    localparam logic [3:0] POS_CENTRE = 4'd4;

    function automatic logic [3:0] clamp_pos(input logic [3:0] pos);
        logic [3:0] p;
        if (pos > POS_MAX) begin
            p = POS_MAX;
        end else begin
            p = pos;
        end
        return p;
    endfunction

    // A sweep entered at the right edge must head back left.
    function automatic pan_state_e entry_state(input pan_mode_e mode, input logic [3:0] pos);
        pan_state_e st;
        case (mode)
            PAN_OFF:    st = ST_CENTRE;
            PAN_MANUAL: st = ST_MANUAL;
            PAN_SWEEP:  st = (pos == POS_MAX) ? ST_SWEEP_DOWN : ST_SWEEP_UP;
            PAN_ROTATE: st = ST_ROTATE;
            default:    st = ST_CENTRE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pan_dwell_counter.sv
// Counts sample ticks and pulses tc on the tick that completes a dwell period.
// A dwell of zero behaves as a dwell of one.
module pan_dwell_counter
    import pan_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] dwell,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] last_s;

    // Final count value of the period, with zero dwell folded onto one.
    always_comb begin
        if (dwell == {CNT_W{1'b0}}) begin
            last_s = {CNT_W{1'b0}};
        end else begin
            last_s = dwell - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign tc = tick && (count_r == last_s);

    // Tick counter, restarted on clear or on completing a period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear || tc) begin
            count_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pan_sequencer.sv
// Steps a stereo pan position in centre/manual/sweep/rotate modes and drives
// complementary gains. Define PAN_SMOOTH_EN to make MANUAL glide to its target.
module pan_sequencer
    import pan_pkg::*;
#(
    parameter int               CNT_W         = 16,
    parameter logic [CNT_W-1:0] DEFAULT_DWELL = CNT_W'(48000),
    parameter logic [1:0]       DEFAULT_MODE  = 2'd2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [3:0]       cfg_pos,
    input  logic [CNT_W-1:0] cfg_dwell,
    output logic [3:0]       pan_pos,
    output logic [3:0]       gain_l,
    output logic [3:0]       gain_r,
    output logic             step_strobe
);

    pan_state_e       state_r, state_s;
    pan_mode_e        mode_r, mode_s, pend_mode_r, pend_mode_s;
    logic [3:0]       pos_r, pos_s, target_r, target_s, pend_target_r, pend_target_s;
    logic [CNT_W-1:0] dwell_r, dwell_s, pend_dwell_r, pend_dwell_s;
    logic             pend_r, pend_s;
    logic [3:0]       gain_l_r, gain_r_r;
    logic             strobe_r, ready_r;
    logic             accept_s, boundary_s, cnt_tick_s, cnt_clear_s;

    function automatic logic [3:0] entry_pos(input pan_mode_e mode, input logic [3:0] pos,
                                             input logic [3:0] target);
        logic [3:0] p;
        case (mode)
            PAN_OFF:    p = POS_CENTRE;
`ifdef PAN_SMOOTH_EN
            PAN_MANUAL: p = pos;
`else
            PAN_MANUAL: p = target;
`endif
            default:    p = pos;
        endcase
        return p;
    endfunction

    assign accept_s    = cfg_valid && ready_r;
    assign cnt_tick_s  = sample_tick && enable && (state_r != ST_IDLE);
    assign cnt_clear_s = !enable || (state_r == ST_IDLE);

    pan_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear_s),
        .tick  (cnt_tick_s),
        .dwell (dwell_r),
        .tc    (boundary_s)
    );

    // Next state, position and config bookkeeping.
    always_comb begin
        state_s       = state_r;
        pos_s         = pos_r;
        mode_s        = mode_r;
        dwell_s       = dwell_r;
        target_s      = target_r;
        pend_s        = pend_r;
        pend_mode_s   = pend_mode_r;
        pend_target_s = pend_target_r;
        pend_dwell_s  = pend_dwell_r;
        if (!enable) begin
            state_s = ST_IDLE;
            pos_s   = POS_CENTRE;
            pend_s  = 1'b0;
            if (pend_r) begin
                mode_s   = pend_mode_r;
                dwell_s  = pend_dwell_r;
                target_s = pend_target_r;
            end else if (accept_s) begin
                mode_s   = pan_mode_e'(cfg_mode);
                dwell_s  = cfg_dwell;
                target_s = clamp_pos(cfg_pos);
            end else begin
                mode_s = mode_r;
            end
        end else begin
            if (state_r == ST_IDLE) begin
                state_s = entry_state(mode_r, pos_r);
                pos_s   = entry_pos(mode_r, pos_r, target_r);
            end else if (boundary_s && pend_r) begin
                // A pending config replaces the step at this boundary.
                mode_s   = pend_mode_r;
                dwell_s  = pend_dwell_r;
                target_s = pend_target_r;
                pend_s   = 1'b0;
                state_s  = entry_state(pend_mode_r, pos_r);
                pos_s    = entry_pos(pend_mode_r, pos_r, pend_target_r);
            end else if (boundary_s) begin
                case (state_r)
                    ST_SWEEP_UP: begin
                        pos_s   = pos_r + 4'd1;
                        state_s = (pos_r + 4'd1 >= POS_MAX) ? ST_SWEEP_DOWN : ST_SWEEP_UP;
                    end
                    ST_SWEEP_DOWN: begin
                        pos_s   = pos_r - 4'd1;
                        state_s = (pos_r <= 4'd1) ? ST_SWEEP_UP : ST_SWEEP_DOWN;
                    end
                    ST_ROTATE: begin
                        pos_s = (pos_r == POS_MAX) ? 4'd0 : pos_r + 4'd1;
                    end
`ifdef PAN_SMOOTH_EN
                    ST_MANUAL: begin
                        if (pos_r < target_r) begin
                            pos_s = pos_r + 4'd1;
                        end else if (pos_r > target_r) begin
                            pos_s = pos_r - 4'd1;
                        end else begin
                            pos_s = pos_r;
                        end
                    end
`endif
                    default: begin
                        pos_s = pos_r;
                    end
                endcase
            end else begin
                pos_s = pos_r;
            end
            if (accept_s) begin
                pend_s        = 1'b1;
                pend_mode_s   = pan_mode_e'(cfg_mode);
                pend_target_s = clamp_pos(cfg_pos);
                pend_dwell_s  = cfg_dwell;
            end else begin
                pend_mode_s = pend_mode_r;
            end
        end
    end

    // State, config and registered output update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            pos_r         <= POS_CENTRE;
            mode_r        <= pan_mode_e'(DEFAULT_MODE);
            dwell_r       <= DEFAULT_DWELL;
            target_r      <= POS_CENTRE;
            pend_r        <= 1'b0;
            pend_mode_r   <= PAN_OFF;
            pend_target_r <= POS_CENTRE;
            pend_dwell_r  <= {CNT_W{1'b0}};
            gain_l_r      <= POS_CENTRE;
            gain_r_r      <= POS_CENTRE;
            strobe_r      <= 1'b0;
            ready_r       <= 1'b1;
        end else begin
            state_r       <= state_s;
            pos_r         <= pos_s;
            mode_r        <= mode_s;
            dwell_r       <= dwell_s;
            target_r      <= target_s;
            pend_r        <= pend_s;
            pend_mode_r   <= pend_mode_s;
            pend_target_r <= pend_target_s;
            pend_dwell_r  <= pend_dwell_s;
            gain_l_r      <= POS_MAX - pos_s;
            gain_r_r      <= pos_s;
            strobe_r      <= (pos_s != pos_r);
            ready_r       <= !pend_s;
        end
    end

    assign pan_pos     = pos_r;
    assign gain_l      = gain_l_r;
    assign gain_r      = gain_r_r;
    assign step_strobe = strobe_r;
    assign cfg_ready   = ready_r;

endmodule

// File: tb/tb_pan_sequencer.sv
// Self-checking bench for pan_sequencer: vector table, directed corner cases
// and random stimulus against a behavioural model (honours PAN_SMOOTH_EN).
module tb_pan_sequencer;

    localparam int CNT_W = 16;
`ifdef PAN_SMOOTH_EN
    localparam bit SMOOTH = 1'b1;
`else
    localparam bit SMOOTH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             sample_tick = 1'b0;
    logic             enable = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [1:0]       cfg_mode = 2'd0;
    logic [3:0]       cfg_pos = 4'd0;
    logic [CNT_W-1:0] cfg_dwell = 16'd0;
    logic             cfg_ready, step_strobe;
    logic [3:0]       pan_pos, gain_l, gain_r;

    pan_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_pos(cfg_pos), .cfg_dwell(cfg_dwell), .pan_pos(pan_pos),
        .gain_l(gain_l), .gain_r(gain_r), .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position plus a sweep direction instead of states.
    int m_pos, m_mode, m_dwell, m_target, m_cnt, m_dir, p_mode, p_target, p_dwell;
    bit m_run, m_pend, m_ready, m_strobe;

    task automatic model_reset();
        m_pos = 4; m_mode = 2; m_dwell = 48000; m_target = 4; m_cnt = 0;
        m_dir = 1; m_run = 0; m_pend = 0; m_ready = 1; m_strobe = 0;
    endtask

    task automatic model_enter(input int mode, input int target);
        case (mode)
            0: m_pos = 4;
            1: m_pos = SMOOTH ? m_pos : target;
            2: m_dir = (m_pos == 8) ? -1 : 1;
            default: ;
        endcase
    endtask

    task automatic model_step();
        case (m_mode)
            1: if (SMOOTH) m_pos = m_pos + ((m_target > m_pos) ? 1 : 0) - ((m_target < m_pos) ? 1 : 0);
            2: begin
                m_pos = m_pos + m_dir;
                if (m_pos == 8) m_dir = -1;
                else if (m_pos == 0) m_dir = 1;
            end
            3: m_pos = (m_pos == 8) ? 0 : m_pos + 1;
            default: ;
        endcase
    endtask

    task automatic model_clock(input bit en, input bit tk, input bit vl, input int md,
                               input int ps, input int dw);
        bit acc;
        int prev, eff;
        acc  = vl && m_ready;
        prev = m_pos;
        if (!en) begin
            if (m_pend) begin
                m_mode = p_mode; m_dwell = p_dwell; m_target = p_target;
            end else if (acc) begin
                m_mode = md; m_dwell = dw; m_target = (ps > 8) ? 8 : ps;
            end
            m_pend = 0; m_run = 0; m_pos = 4; m_cnt = 0;
        end else begin
            if (!m_run) begin
                m_run = 1; m_cnt = 0;
                model_enter(m_mode, m_target);
            end else if (tk) begin
                eff = (m_dwell == 0) ? 1 : m_dwell;
                if (m_cnt == eff - 1) begin
                    m_cnt = 0;
                    if (m_pend) begin
                        m_mode = p_mode; m_dwell = p_dwell; m_target = p_target; m_pend = 0;
                        model_enter(m_mode, m_target);
                    end else begin
                        model_step();
                    end
                end else begin
                    m_cnt++;
                end
            end
            if (acc) begin
                m_pend = 1; p_mode = md; p_dwell = dw; p_target = (ps > 8) ? 8 : ps;
            end
        end
        m_ready  = !m_pend;
        m_strobe = (m_pos != prev);
    endtask

    task automatic drive(input bit en, input bit tk, input bit vl, input int md,
                         input int ps, input int dw);
        enable = en; sample_tick = tk; cfg_valid = vl;
        cfg_mode = md[1:0]; cfg_pos = ps[3:0]; cfg_dwell = dw[CNT_W-1:0];
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_clock(enable, sample_tick, cfg_valid, cfg_mode, cfg_pos, cfg_dwell);
        @(negedge clk);
        check("model_pan_pos", pan_pos, m_pos);
        check("model_gain_l", gain_l, 8 - m_pos);
        check("model_gain_r", gain_r, m_pos);
        check("model_strobe", step_strobe, m_strobe);
        check("model_ready", cfg_ready, m_ready);
    endtask

    typedef struct {
        bit en; bit tk; bit vl; int md; int ps; int dw;
        int e_pos; int e_rdy; int e_stb;
    } vec_t;

    function automatic vec_t mk(input bit en, input bit tk, input bit vl, input int md,
                                input int ps, input int dw, input int ep, input int er,
                                input int es);
        vec_t v;
        v.en = en; v.tk = tk; v.vl = vl; v.md = md; v.ps = ps; v.dw = dw;
        v.e_pos = ep; v.e_rdy = er; v.e_stb = es;
        return v;
    endfunction

    vec_t vecs[15];
    int   seen[$];
    int   last_t, found;

    initial begin
        // Row 8 accepts on a boundary; row 10 applies it one tick later.
        vecs[0]  = mk(0, 0, 1, 3, 0, 1, 4, 1, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 4, 1, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 0, 5, 1, 1);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 5, 1, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0, 0, 6, 1, 1);
        vecs[5]  = mk(1, 1, 0, 0, 0, 0, 7, 1, 1);
        vecs[6]  = mk(1, 1, 0, 0, 0, 0, 8, 1, 1);
        vecs[7]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[8]  = mk(1, 1, 1, 1, 12, 3, 1, 0, 1);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 0, 0, SMOOTH ? 1 : 8, 1, SMOOTH ? 0 : 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 4, 1, 1);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 4, 1, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 5, 4, 1, 0);
        vecs[14] = mk(1, 0, 0, 0, 0, 0, 4, 1, 0);

        model_reset();
        #12;
        check("reset_pan_pos", pan_pos, 4);
        check("reset_gain_l", gain_l, 4);
        check("reset_gain_r", gain_r, 4);
        check("reset_ready", cfg_ready, 1);
        check("reset_strobe", step_strobe, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].en, vecs[i].tk, vecs[i].vl, vecs[i].md, vecs[i].ps, vecs[i].dw);
            cyc();
            check($sformatf("vec%0d_pan_pos", i), pan_pos, vecs[i].e_pos);
            check($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_strobe", i), step_strobe, vecs[i].e_stb);
        end

        // Sweep, dwell 2, a tick every fourth cycle: one step per 8 cycles.
        drive(0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 2, 0, 2); cyc();
        last_t = -1;
        for (int i = 0; i < 72; i++) begin
            drive(1, (i % 4) == 3, 0, 0, 0, 0);
            cyc();
            if (step_strobe) begin
                seen.push_back(pan_pos);
                if (last_t >= 0) check("sweep_interval", i - last_t, 8);
                last_t = i;
            end
        end
        check("sweep_steps", seen.size(), 9);
        for (int i = 0; i < seen.size() && i < 9; i++)
            check($sformatf("sweep_pos%0d", i), seen[i], (i < 4) ? 5 + i : 11 - i);

        // Rotate with dwell 0 steps on every tick.
        drive(0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 3, 0, 0); cyc();
        drive(1, 0, 0, 0, 0, 0); cyc();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 0, 0); cyc();
            check($sformatf("rotate_pos%0d", i), pan_pos, (i < 4) ? 5 + i : i - 4);
        end

        // Manual config offered mid-dwell during a sweep at position 6.
        drive(0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 2, 0, 4); cyc();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            drive(1, 1, 0, 0, 0, 0); cyc();
            if (pan_pos == 4'd6) found = 1;
        end
        check("wait_pos6", found, 1);
        drive(1, 1, 1, 1, 12, 4); cyc();
        check("cfg_ready_low", cfg_ready, 0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            drive(1, 1, 0, 0, 0, 0); cyc();
            if (cfg_ready) found = 1;
        end
        check("wait_ready_back", found, 1);
        check("manual_apply_pos", pan_pos, SMOOTH ? 6 : 8);
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, 0, 0, 0); cyc();
        end
        check("manual_hold_pos", pan_pos, 8);

`ifdef PAN_SMOOTH_EN
        // Glide from centre down to a manual target of 0.
        drive(0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 1, 0, 1); cyc();
        drive(1, 0, 0, 0, 0, 0); cyc();
        check("glide_entry_pos", pan_pos, 4);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 0, 0); cyc();
            check($sformatf("glide_pos%0d", i), pan_pos, (i < 4) ? 3 - i : 0);
        end
`endif

        // Asynchronous reset mid-sweep at position 7, checked between edges.
        drive(0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 1, 2, 0, 1); cyc();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            drive(1, 1, 0, 0, 0, 0); cyc();
            if (pan_pos == 4'd7) found = 1;
        end
        check("wait_pos7", found, 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_pan_pos", pan_pos, 4);
        check("async_reset_gain_l", gain_l, 4);
        check("async_reset_gain_r", gain_r, 4);
        check("async_reset_ready", cfg_ready, 1);
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 16) != 0, $urandom % 2, ($urandom % 4) == 0,
                  $urandom % 4, $urandom % 16, $urandom % 4);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
